gate_stimulus_gen: RTL and testbench

Synthesizable stimulus source that drives the A/B/C inputs of the three-input AND-gate stage directly downstream.
- TOGGLE mode: free-running square waves on A, B and C, each with its own half-period. This is the clocked equivalent of the 100/70/50 toggle pattern.
- SWEEP mode: an exhaustive walk through all 8 input codes with a programmable dwell per code, then a done flag.
- Registered outputs connect straight to the gate's A, B, C ports.

---
 rtl/gate_stimulus_gen_pkg.sv | 20 ++
 rtl/gate_stimulus_gen_if.sv | 26 ++
 rtl/gate_stimulus_gen_half_period_toggler.sv | 44 ++++
 rtl/gate_stimulus_gen.sv | 126 ++++++++++++
 tb/tb_gate_stimulus_gen.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/gate_stimulus_gen_pkg.sv
// Shared types for the AND-gate stimulus source: FSM states, run modes and
// the 3-bit {A,B,C} code.
package gate_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOGGLE = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  typedef logic [2:0] code_t;

  localparam code_t CODE_FIRST = 3'b000;
  localparam code_t CODE_LAST  = 3'b111;

endpackage

// File: rtl/gate_stimulus_gen_if.sv
// Control and stimulus bundle between the stimulus source (slave side)
// and whoever requests runs and observes the A/B/C stimulus (master side).
interface gate_stimulus_gen_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic             mode;
  logic [CNT_W-1:0] step_len;
  logic             A;
  logic             B;
  logic             C;
  logic             chg;
  logic             done;

  modport master (
    output en, mode, step_len,
    input  A, B, C, chg, done
  );

  modport slave (
    input  en, mode, step_len,
    output A, B, C, chg, done
  );

endinterface

// File: rtl/gate_stimulus_gen_half_period_toggler.sv
// Square-wave source: q flips every HALF cycles while run is high; counter
// and q return to 0 whenever run is low.
module half_period_toggler #(
  parameter int unsigned HALF  = 100,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  always_comb begin
    cnt_d = '0;
    q_d   = 1'b0;
    if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        q_d   = ~q_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        q_d   = q_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gate_stimulus_gen.sv
// Drives A/B/C of the downstream AND gate: free-running square waves
// (TOGGLE) or an 8-code exhaustive walk with programmable dwell (SWEEP).
module gate_stimulus_gen
  import gate_stim_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HALF_A = 100,
  parameter int unsigned HALF_B = 70,
  parameter int unsigned HALF_C = 50
) (
  input  logic                clk,
  input  logic                rst,
  gate_stimulus_gen_if.slave  bus
);

  state_t           state_q, state_d;
  code_t            abc_q, abc_d;
  code_t            code_q, code_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             chg_q, chg_d;
  logic             done_q, done_d;

  logic tgl_run;
  logic tq_a, tq_b, tq_c;

  // Togglers start one cycle early (on the IDLE->TOGGLE edge) so that their
  // registered q, re-registered into abc_q, lands exactly at t = HALF_x.
  assign tgl_run = bus.en &&
                   (((state_q == ST_IDLE) && (bus.mode == MODE_TOGGLE)) ||
                    (state_q == ST_TOGGLE));

  half_period_toggler #(.HALF(HALF_A), .CNT_W(CNT_W)) u_tgl_a (
    .clk(clk), .rst(rst), .run(tgl_run), .q(tq_a)
  );
  half_period_toggler #(.HALF(HALF_B), .CNT_W(CNT_W)) u_tgl_b (
    .clk(clk), .rst(rst), .run(tgl_run), .q(tq_b)
  );
  half_period_toggler #(.HALF(HALF_C), .CNT_W(CNT_W)) u_tgl_c (
    .clk(clk), .rst(rst), .run(tgl_run), .q(tq_c)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    len_d   = len_q;
    abc_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        code_d  = CODE_FIRST;
        dwell_d = '0;
        if (bus.en) begin
          if (bus.mode == MODE_SWEEP) begin
            state_d = ST_SWEEP;
            len_d   = (bus.step_len == '0) ? CNT_W'(1) : bus.step_len;
          end else begin
            state_d = ST_TOGGLE;
          end
        end
      end
      ST_TOGGLE: begin
        if (!bus.en) state_d = ST_IDLE;
        else         abc_d   = {tq_a, tq_b, tq_c};
      end
      ST_SWEEP: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          code_d  = CODE_FIRST;
          dwell_d = '0;
        end else if (dwell_q == len_q - CNT_W'(1)) begin
          dwell_d = '0;
          if (code_q == CODE_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            abc_d   = CODE_LAST;
          end else begin
            code_d = code_q + 3'd1;
            abc_d  = code_d;
          end
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
          abc_d   = code_q;
        end
      end
      ST_DONE: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
        end else begin
          abc_d  = CODE_LAST;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    chg_d = (abc_d != abc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      abc_q   <= '0;
      code_q  <= '0;
      dwell_q <= '0;
      len_q   <= '0;
      chg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      len_q   <= len_d;
      chg_q   <= chg_d;
      done_q  <= done_d;
    end
  end

  assign bus.A    = abc_q[2];
  assign bus.B    = abc_q[1];
  assign bus.C    = abc_q[0];
  assign bus.chg  = chg_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gate_stimulus_gen.sv
// Bench for gate_stimulus_gen with HALF_A/B/C = 4/3/2: vector table plus
// sequences compared against a closed-form model of the waveforms.
module tb_gate_stimulus_gen;

  localparam int unsigned CW = 8;
  localparam int HA = 4;
  localparam int HB = 3;
  localparam int HC = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  gate_stimulus_gen_if #(.CNT_W(CW)) bus ();

  gate_stimulus_gen #(
    .CNT_W(CW), .HALF_A(HA), .HALF_B(HB), .HALF_C(HC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] step;
    logic [4:0] exp;   // {A,B,C,chg,done}
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outv();
    return {bus.A, bus.B, bus.C, bus.chg, bus.done};
  endfunction

  task automatic check_vec(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ABC=%b chg=%b done=%b, expected ABC=%b chg=%b done=%b",
               nm, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // t counts cycles from the first cycle of the run (t=0).
  function automatic logic [4:0] toggle_exp(input int t);
    logic a, b, c, ch;
    a  = ((t / HA) % 2) == 1;
    b  = ((t / HB) % 2) == 1;
    c  = ((t / HC) % 2) == 1;
    ch = (t > 0) && ((t % HA == 0) || (t % HB == 0) || (t % HC == 0));
    return {a, b, c, ch, 1'b0};
  endfunction

  function automatic logic [4:0] sweep_exp(input int t, input int len);
    logic [2:0] code;
    if (t < 8 * len) begin
      code = 3'(t / len);
      return {code, (t > 0) && (t % len == 0), 1'b0};
    end
    return {3'b111, 1'b0, 1'b1};
  endfunction

  // Starts a run from IDLE, checks ncyc cycles, then drops en and checks
  // the clear cycle and one idle cycle.
  task automatic run_seq(input string nm, input logic m, input logic [7:0] step,
                         input int ncyc, input bit flip);
    int         len;
    logic [4:0] e;
    logic [2:0] last;
    len = (step == 8'd0) ? 1 : int'(step);
    last = 3'b000;
    bus.en = 1'b1;
    bus.mode = m;
    bus.step_len = step;
    for (int t = 0; t < ncyc; t++) begin
      tick();
      e = m ? sweep_exp(t, len) : toggle_exp(t);
      check_vec($sformatf("%s t=%0d", nm, t), outv(), e);
      last = e[4:2];
      if (flip) begin
        bus.mode = ~bus.mode;
        bus.step_len = 8'($urandom);
      end
    end
    bus.en = 1'b0;
    tick();
    check_vec({nm, " clear"}, outv(), {3'b000, |last, 1'b0});
    tick();
    check_vec({nm, " idle"}, outv(), 5'b00000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst, en, mode, step, {A,B,C,chg,done}
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'd0, 5'b000_0_0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd0, 5'b000_0_0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'd0, 5'b000_0_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'd0, 5'b000_0_0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'd0, 5'b000_0_0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd5, 5'b001_1_0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd5, 5'b010_1_0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b011_1_0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b100_1_0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b101_1_0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b110_1_0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b111_1_0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'd9, 5'b111_0_1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd9, 5'b111_0_1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'd9, 5'b000_1_0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'd9, 5'b000_0_0};

    rst = tbl[0].rst;
    bus.en = tbl[0].en;
    bus.mode = tbl[0].mode;
    bus.step_len = tbl[0].step;
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      bus.en = tbl[i].en;
      bus.mode = tbl[i].mode;
      bus.step_len = tbl[i].step;
      tick();
      check_vec($sformatf("table[%0d]", i), outv(), tbl[i].exp);
    end

    // TOGGLE two full LCM periods with mode flipping mid-run; afterwards
    // the SWEEP request only takes effect from IDLE.
    run_seq("toggle_flip", 1'b0, 8'd0, 50, 1'b1);
    run_seq("sweep_L3", 1'b1, 8'd3, 30, 1'b0);
    run_seq("abort101", 1'b1, 8'd2, 11, 1'b0);

    // Reset mid-TOGGLE with en still high.
    bus.en = 1'b1;
    bus.mode = 1'b0;
    for (int t = 0; t < 9; t++) begin
      tick();
      check_vec($sformatf("pre_rst t=%0d", t), outv(), toggle_exp(t));
    end
    rst = 1'b1;
    tick();
    check_vec("rst_mid_toggle", outv(), 5'b00000);
    rst = 1'b0;
    bus.en = 1'b0;
    tick();
    check_vec("post_rst idle", outv(), 5'b00000);

    for (int k = 0; k < 24; k++) begin
      logic       m;
      logic [7:0] st;
      int         len;
      int         n;
      m   = 1'($urandom);
      st  = 8'($urandom_range(0, 6));
      len = (st == 8'd0) ? 1 : int'(st);
      n   = m ? $urandom_range(1, 8 * len + 4) : $urandom_range(1, 40);
      run_seq($sformatf("rand%0d m=%0d L=%0d", k, m, st), m, st, n, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
